instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, meaning the maximum number of instruction words buffered per program.
REQ-002 The module SHALL have parameter RST_CYC, default 1, meaning the number of cycles cpu_reset is held high after a load.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the host offers in_word.
REQ-006 The module SHALL have port in_word, input, 32 bits: the instruction word from the host.
REQ-007 The module SHALL have port in_last, input, 1 bit: qualifies in_word as the final word of the program.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-009 The module SHALL have port LoadInstructions, output, 1 bit: drives the CPU load-enable.
REQ-010 The module SHALL have port Instruction, output, 32 bits: the word written into CPU instruction memory.
REQ-011 The module SHALL have port cpu_reset, output, 1 bit: drives the CPU Reset to start execution.
REQ-012 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The module SHALL have port done, output, 1 bit: sticky flag, program delivered.
REQ-014 The module SHALL have port trunc, output, 1 bit: sticky flag, program exceeded DEPTH and was cut.

Function
REQ-015 The FSM SHALL have states IDLE, FILL, DRAIN and START, with all outputs registered except in_ready.
REQ-016 A word SHALL be accepted on a rising edge only when in_valid=1 and in_ready=1; each accepted word is written to buf[wr] and wr/count increment.
REQ-017 in_ready SHALL be 1 in IDLE and in FILL, 0 in DRAIN and START, and 0 while Reset is high.
REQ-018 IDLE: an accept with in_last=0 SHALL go to FILL; an accept with in_last=1 SHALL go to DRAIN; any accept SHALL clear done and trunc.
REQ-019 FILL: an accept with in_last=1 SHALL go to DRAIN.
REQ-020 FILL: an accept that makes count=DEPTH with in_last=0 SHALL go to DRAIN and set trunc=1; further words are never accepted for this program.
REQ-021 DRAIN SHALL run for exactly count cycles; on cycle k (k=0..count-1) LoadInstructions=1 and Instruction=buf[k], in acceptance order, with no gaps.
REQ-022 The first DRAIN output SHALL appear on the cycle after the in_last (or DEPTH-th) accept.
REQ-023 After the last DRAIN cycle, the FSM SHALL go to START: LoadInstructions=0, Instruction=0, and cpu_reset=1 for exactly RST_CYC cycles.
REQ-024 On the cycle after START ends, the FSM SHALL return to IDLE with cpu_reset=0 and done=1, and wr/rd/count cleared.
REQ-025 LoadInstructions and cpu_reset SHALL never be high in the same cycle.
REQ-026 in_valid asserted in DRAIN or START SHALL be ignored, with no buffer write.
REQ-027 Counters SHALL be ceil(log2(DEPTH))+1 bits wide and never wrap; count is always between 1 and DEPTH when entering DRAIN.
REQ-028 Changes on in_word or in_last without an accept SHALL have no effect.

Reset
REQ-029 While Reset=1, the module SHALL immediately hold state=IDLE, LoadInstructions=0, Instruction=0, cpu_reset=0, busy=0, done=0, trunc=0, in_ready=0, and wr/rd/count=0.
REQ-030 Reset asserted mid-FILL, mid-DRAIN or mid-START SHALL discard the buffered program; no further LoadInstructions or cpu_reset pulse occurs.
REQ-031 Buffer contents need not be cleared by reset.
REQ-032 On the first edge after Reset falls, in_ready SHALL be 1.

Verification
REQ-033 Scenario: 13 words streamed back-to-back (0x20010008, 0x20020017, ... 0x016C682A), with in_last on the 13th -> 13 consecutive LoadInstructions=1 cycles in the same order, then 1 cycle of cpu_reset=1, then done=1 and busy=0.
REQ-034 Scenario: a single word 0x20010008 with in_last=1 from IDLE -> exactly 1 load cycle with Instruction=0x20010008, then cpu_reset for 1 cycle.
REQ-035 Scenario: 17 words with in_last never set, DEPTH=16 -> in_ready=0 after the 16th accept, trunc=1, exactly 16 words drained, and the 17th word is never seen on Instruction.
REQ-036 Scenario: 5 words with random in_valid gaps, plus in_valid held during DRAIN -> order is preserved, the DRAIN-time offers are not accepted, and there are 5 load cycles.
REQ-037 Scenario: Reset pulsed after the 3rd DRAIN cycle of an 8-word program -> LoadInstructions=0 asynchronously, no cpu_reset pulse, done=0, and in_ready=1 after release.
REQ-038 Scenario: a second 2-word program sent after done=1 -> done clears on its first accept, 2 load cycles follow, then done=1 again; with RST_CYC=3, cpu_reset is high for 3 cycles.

Source files
------------

// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
//
// Buffers a program of 32-bit instruction words streamed in by a host
// (valid/ready handshake). When the last word arrives, or the buffer fills,
// it replays the words to the CPU instruction memory on consecutive cycles.
// It then pulses the CPU reset for RST_CYC cycles so the CPU starts executing
// the freshly loaded program.
//
// Parameters
//   DEPTH    maximum number of instruction words buffered per program
//   RST_CYC  number of cycles cpu_reset is held high after a load (>= 1)
//
// Ports
//   clk              rising-edge clock
//   Reset            asynchronous, active-high reset
//   in_valid         host offers in_word
//   in_word[31:0]    instruction word from the host
//   in_last          in_word is the final word of the program
//   in_ready         loader accepts a word this cycle (combinational)
//   LoadInstructions CPU instruction-memory load enable (registered)
//   Instruction      word written into CPU instruction memory (registered)
//   cpu_reset        CPU reset pulse that starts execution (registered)
//   busy             loader is in any state other than IDLE (registered)
//   done             sticky: last program fully delivered (registered)
//   trunc            sticky: last program exceeded DEPTH and was cut
// ---------------------------------------------------------------------------
module instr_loader #(
  parameter int DEPTH   = 16,
  parameter int RST_CYC = 1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        in_valid,
  input  logic [31:0] in_word,
  input  logic        in_last,
  output logic        in_ready,
  output logic        LoadInstructions,
  output logic [31:0] Instruction,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        trunc
);

  localparam int DATA_W = 32;
  // Counters carry one extra bit so count can hold DEPTH itself without wrapping.
  localparam int CW = $clog2(DEPTH) + 1;
  // Buffer address width; a one-entry buffer still needs a 1-bit address.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = $clog2(RST_CYC + 1) + 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [RW-1:0] RST_CYC_C = RW'(RST_CYC);
  localparam logic [RW-1:0] RCNT_ONE  = RW'(1);
  localparam logic [AW-1:0] FIRST_IDX = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    START = 2'd3
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] wr, wr_n;
  logic [CW-1:0] rd, rd_n;
  logic [CW-1:0] count, count_n;
  logic [RW-1:0] rcnt, rcnt_n;

  logic              li_n;
  logic              cr_n;
  logic              busy_n;
  logic              done_n;
  logic              trunc_n;
  logic [DATA_W-1:0] instr_n;

  logic accept;

  // Program buffer: data only, never reset.
  logic [DATA_W-1:0] mem [DEPTH];

  // Handshake: ready only while collecting words, and forced low during reset.
  assign in_ready = ~Reset & ((state == IDLE) | (state == FILL));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr[AW-1:0]] <= in_word;
    end
  end

  // Next-state and next-output logic. All outputs except in_ready are
  // registered, so the values computed here are what the CPU sees during the
  // cycle that follows the edge.
  always_comb begin
    state_n = state;
    wr_n    = wr;
    rd_n    = rd;
    count_n = count;
    rcnt_n  = rcnt;
    li_n    = 1'b0;
    cr_n    = 1'b0;
    instr_n = '0;
    done_n  = done;
    trunc_n = trunc;

    case (state)
      IDLE, FILL: begin
        if (accept) begin
          wr_n    = wr + CNT_ONE;
          count_n = count + CNT_ONE;
          if (state == IDLE) begin
            // A new program invalidates the status of the previous one.
            done_n  = 1'b0;
            trunc_n = 1'b0;
            state_n = FILL;
          end
          if (in_last || (count_n == DEPTH_C)) begin
            state_n = DRAIN;
            if (!in_last) begin
              trunc_n = 1'b1;
            end
            // The first load cycle immediately follows this accept. For a
            // single-word program word 0 is being written on this very edge,
            // so it is taken straight from the input instead of the buffer.
            li_n    = 1'b1;
            instr_n = (count == '0) ? in_word : mem[FIRST_IDX];
            rd_n    = CNT_ONE;
          end
        end
      end

      DRAIN: begin
        // rd is the index of the next word to present; word 0 was already
        // presented on entry, so DRAIN lasts exactly count cycles.
        if (rd < count) begin
          li_n    = 1'b1;
          instr_n = mem[rd[AW-1:0]];
          rd_n    = rd + CNT_ONE;
        end else begin
          state_n = START;
          cr_n    = 1'b1;
          rcnt_n  = RCNT_ONE;
        end
      end

      START: begin
        if (rcnt < RST_CYC_C) begin
          cr_n   = 1'b1;
          rcnt_n = rcnt + RCNT_ONE;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
          wr_n    = '0;
          rd_n    = '0;
          count_n = '0;
          rcnt_n  = '0;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state            <= IDLE;
      wr               <= '0;
      rd               <= '0;
      count            <= '0;
      rcnt             <= '0;
      LoadInstructions <= 1'b0;
      Instruction      <= '0;
      cpu_reset        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      trunc            <= 1'b0;
    end else begin
      state            <= state_n;
      wr               <= wr_n;
      rd               <= rd_n;
      count            <= count_n;
      rcnt             <= rcnt_n;
      LoadInstructions <= li_n;
      Instruction      <= instr_n;
      cpu_reset        <= cr_n;
      busy             <= busy_n;
      done             <= done_n;
      trunc            <= trunc_n;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_loader
//
// Two loader instances: dut0 with default parameters (DEPTH=16, RST_CYC=1)
// and dut1 with RST_CYC=3. Stimulus pushes the expected CPU-side output
// cycles (load word / reset pulse) into a per-instance queue; a monitor per
// instance pops and compares whenever LoadInstructions or cpu_reset is high.
// ---------------------------------------------------------------------------
module tb_instr_loader;

  logic        clk;
  logic        rst0, rst1;
  logic        v0, v1, l0, l1;
  logic [31:0] w0, w1;
  logic        r0, r1, li0, li1, cr0, cr1, bs0, bs1, dn0, dn1, tr0, tr1;
  logic [31:0] ins0, ins1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        li;
    logic        cr;
    logic [31:0] w;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int li_seen[2];
  int cr_seen[2];
  int li_rise[2];
  int cr_rise[2];
  int li_base, cr_base, lr_base, cr_rbase;
  logic li0_prev, li1_prev, cr0_prev, cr1_prev;

  instr_loader dut0 (
    .clk(clk), .Reset(rst0), .in_valid(v0), .in_word(w0), .in_last(l0),
    .in_ready(r0), .LoadInstructions(li0), .Instruction(ins0),
    .cpu_reset(cr0), .busy(bs0), .done(dn0), .trunc(tr0)
  );

  instr_loader #(.DEPTH(16), .RST_CYC(3)) dut1 (
    .clk(clk), .Reset(rst1), .in_valid(v1), .in_word(w1), .in_last(l1),
    .in_ready(r1), .LoadInstructions(li1), .Instruction(ins1),
    .cpu_reset(cr1), .busy(bs1), .done(dn1), .trunc(tr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic [31:0] w, input logic l);
    if (k == 0) begin
      v0 = v; w0 = w; l0 = l;
    end else begin
      v1 = v; w1 = w; l1 = l;
    end
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? r0 : r1;
  endfunction

  function automatic logic bsy(input int k);
    return (k == 0) ? bs0 : bs1;
  endfunction

  task automatic push_load(input int k, input logic [31:0] w);
    exp_t e;
    e.li = 1'b1; e.cr = 1'b0; e.w = w;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic push_rst(input int k, input int n);
    exp_t e;
    e.li = 1'b0; e.cr = 1'b1; e.w = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Offer one word; returns just after the rising edge that accepts it.
  task automatic send(input int k, input logic [31:0] word, input logic last);
    int budget;
    budget = 0;
    @(negedge clk);
    drive(k, 1'b1, word, last);
    while (!rdy(k) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!rdy(k)) begin
      vectors++;
      miscompares++;
      $display("FAIL send_ready_timeout: dut%0d in_ready stayed %b, expected 1", k, rdy(k));
    end
    @(posedge clk);
  endtask

  task automatic wait_idle(input int k);
    int budget;
    budget = 0;
    @(negedge clk);
    while (bsy(k) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk($sformatf("dut%0d_idle_timeout", k), bsy(k), 1'b0);
  endtask

  task automatic snap(input int k);
    li_base  = li_seen[k];
    cr_base  = cr_seen[k];
    lr_base  = li_rise[k];
    cr_rbase = cr_rise[k];
  endtask

  task automatic end_prog(input int k, input string nm, input int eli, input int ecr);
    chk({nm, "_load_cycles"}, li_seen[k] - li_base, eli);
    chk({nm, "_cpu_reset_cycles"}, cr_seen[k] - cr_base, ecr);
    chk({nm, "_load_bursts"}, li_rise[k] - lr_base, (eli > 0) ? 1 : 0);
    chk({nm, "_reset_bursts"}, cr_rise[k] - cr_rbase, (ecr > 0) ? 1 : 0);
  endtask

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin
    exp_t e;
    if (li0) li_seen[0]++;
    if (cr0) cr_seen[0]++;
    if (li0 && !li0_prev) li_rise[0]++;
    if (cr0 && !cr0_prev) cr_rise[0]++;
    li0_prev = li0;
    cr0_prev = cr0;
    if (li0 || cr0) begin
      vectors++;
      if (q0.size() == 0) begin
        miscompares++;
        $display("FAIL dut0_unexpected_output: li=%b cr=%b instr=%h, expected no output", li0, cr0, ins0);
      end else begin
        e = q0.pop_front();
        if ({li0, cr0, ins0} !== {e.li, e.cr, e.w}) begin
          miscompares++;
          $display("FAIL dut0_output: li=%b cr=%b instr=%h, expected li=%b cr=%b instr=%h",
                   li0, cr0, ins0, e.li, e.cr, e.w);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (li1) li_seen[1]++;
    if (cr1) cr_seen[1]++;
    if (li1 && !li1_prev) li_rise[1]++;
    if (cr1 && !cr1_prev) cr_rise[1]++;
    li1_prev = li1;
    cr1_prev = cr1;
    if (li1 || cr1) begin
      vectors++;
      if (q1.size() == 0) begin
        miscompares++;
        $display("FAIL dut1_unexpected_output: li=%b cr=%b instr=%h, expected no output", li1, cr1, ins1);
      end else begin
        e = q1.pop_front();
        if ({li1, cr1, ins1} !== {e.li, e.cr, e.w}) begin
          miscompares++;
          $display("FAIL dut1_output: li=%b cr=%b instr=%h, expected li=%b cr=%b instr=%h",
                   li1, cr1, ins1, e.li, e.cr, e.w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  logic [31:0] prog13 [13];
  int          gaps   [5];

  initial begin
    prog13 = '{32'h20010008, 32'h20020017, 32'h00221820, 32'hAC030004,
               32'h8C040004, 32'h00642022, 32'h10800002, 32'h20840001,
               32'h08000009, 32'h00852824, 32'h00A53025, 32'h3C0D1234,
               32'h016C682A};
    gaps = '{0, 2, 1, 3, 0};
    for (int i = 0; i < 2; i++) begin
      li_seen[i] = 0; cr_seen[i] = 0; li_rise[i] = 0; cr_rise[i] = 0;
    end
    li0_prev = 1'b0; li1_prev = 1'b0; cr0_prev = 1'b0; cr1_prev = 1'b0;
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0);

    // Reset state, with a word offered to show reset blocks acceptance.
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 32'hCAFE0000, 1'b1);
    #1;
    chk("rst_in_ready",    r0,   1'b0);
    chk("rst_load",        li0,  1'b0);
    chk("rst_instruction", ins0, 32'h0);
    chk("rst_cpu_reset",   cr0,  1'b0);
    chk("rst_busy",        bs0,  1'b0);
    chk("rst_done",        dn0,  1'b0);
    chk("rst_trunc",       tr0,  1'b0);
    chk("rst1_in_ready",   r1,   1'b0);
    chk("rst1_busy",       bs1,  1'b0);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    chk("rel_in_ready",  r0, 1'b1);
    chk("rel1_in_ready", r1, 1'b1);

    // 13-word back-to-back program.
    snap(0);
    for (int i = 0; i < 13; i++) push_load(0, prog13[i]);
    push_rst(0, 1);
    for (int i = 0; i < 13; i++) send(0, prog13[i], (i == 12));
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);
    chk("p13_first_load", li0,  1'b1);
    chk("p13_first_word", ins0, 32'h20010008);
    chk("p13_in_ready_drain", r0, 1'b0);
    wait_idle(0);
    end_prog(0, "p13", 13, 1);
    chk("p13_done",  dn0, 1'b1);
    chk("p13_trunc", tr0, 1'b0);

    // Single word.
    snap(0);
    push_load(0, 32'h20010008);
    push_rst(0, 1);
    send(0, 32'h20010008, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);
    chk("p1_first_load", li0, 1'b1);
    chk("p1_busy",       bs0, 1'b1);
    chk("p1_done_clear", dn0, 1'b0);
    wait_idle(0);
    end_prog(0, "p1", 1, 1);
    chk("p1_done", dn0, 1'b1);

    // 17 words without in_last: cut at 16.
    snap(0);
    for (int i = 0; i < 16; i++) push_load(0, 32'h30000000 + i);
    push_rst(0, 1);
    for (int i = 0; i < 16; i++) send(0, 32'h30000000 + i, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 32'h30000010, 1'b0);
    chk("p17_in_ready", r0,  1'b0);
    chk("p17_trunc",    tr0, 1'b1);
    chk("p17_first_word", ins0, 32'h30000000);
    repeat (4) begin
      @(negedge clk);
      chk("p17_in_ready_hold", r0, 1'b0);
    end
    drive(0, 1'b0, 32'h0, 1'b0);
    wait_idle(0);
    end_prog(0, "p17", 16, 1);
    chk("p17_trunc_sticky", tr0, 1'b1);
    chk("p17_done",         dn0, 1'b1);

    // 5 words with gaps, then offers held during DRAIN/START.
    snap(0);
    for (int i = 0; i < 5; i++) push_load(0, 32'h40000001 + i);
    push_rst(0, 1);
    for (int i = 0; i < 5; i++) begin
      if (gaps[i] > 0) begin
        @(negedge clk);
        drive(0, 1'b0, 32'hFFFFFFFF, 1'b1);
        repeat (gaps[i] - 1) @(negedge clk);
      end
      send(0, 32'h40000001 + i, (i == 4));
    end
    repeat (5) begin
      @(negedge clk);
      drive(0, 1'b1, 32'hBADBAD00, 1'b1);
      chk("gap_in_ready_drain", r0, 1'b0);
    end
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);
    wait_idle(0);
    end_prog(0, "gap", 5, 1);
    chk("gap_trunc_cleared", tr0, 1'b0);
    chk("gap_done",          dn0, 1'b1);

    // Reset during DRAIN of an 8-word program, after 3 load cycles.
    snap(0);
    for (int i = 0; i < 3; i++) push_load(0, 32'h50000000 + i);
    for (int i = 0; i < 8; i++) send(0, 32'h50000000 + i, (i == 7));
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    rst0 = 1'b1;
    #1;
    chk("mid_rst_load_async", li0,  1'b0);
    chk("mid_rst_instr",      ins0, 32'h0);
    chk("mid_rst_busy",       bs0,  1'b0);
    chk("mid_rst_in_ready",   r0,   1'b0);
    chk("mid_rst_done",       dn0,  1'b0);
    @(negedge clk);
    rst0 = 1'b0;
    #1;
    chk("mid_rst_rel_in_ready", r0, 1'b1);
    repeat (20) @(negedge clk);
    end_prog(0, "mid_rst", 3, 0);
    chk("mid_rst_done_after", dn0, 1'b0);
    chk("mid_rst_busy_after", bs0, 1'b0);

    // dut1 (RST_CYC=3): one program, then a second 2-word program.
    snap(1);
    push_load(1, 32'h11111111);
    push_rst(1, 3);
    send(1, 32'h11111111, 1'b1);
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 1'b0);
    wait_idle(1);
    end_prog(1, "r3_first", 1, 3);
    chk("r3_first_done", dn1, 1'b1);

    snap(1);
    push_load(1, 32'h22222222);
    push_load(1, 32'h33333333);
    push_rst(1, 3);
    send(1, 32'h22222222, 1'b0);
    #1;
    chk("r3_done_cleared", dn1, 1'b0);
    chk("r3_busy_fill",    bs1, 1'b1);
    send(1, 32'h33333333, 1'b1);
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 1'b0);
    wait_idle(1);
    end_prog(1, "r3_second", 2, 3);
    chk("r3_second_done", dn1, 1'b1);

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
